pll_lock_sequencer: RTL and testbench

Companion controller on the far side of the PLL's rst/locked interface: it drives the PLL reset and consumes the PLL lock indication.
- Runs on the 50 MHz reference clock, so it keeps operating while the PLL is unlocked.
- Holds the PLL in reset and qualifies lock stability.
- Releases the downstream resets in sequence: SDRAM controller first, then the rest of the system.
- Re-sequences automatically on lock loss, lock timeout, or software request.

---
 rtl/pll_seq_pkg.sv | 14 +
 rtl/pll_lock_sync.sv | 15 +
 rtl/pll_lock_sequencer.sv | 80 ++++++++
 tb/tb_pll_lock_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: sequencer state encoding, relock counter width and a max helper for sizing
package pll_seq_pkg;
  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;
  localparam int RELOCK_W = 8;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: STAGES-flop synchronizer, async reset to 0 (clk, rst, d -> q)
module pll_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s;
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '0;
    else s <= {s[STAGES-2:0], d};
  assign q = s[STAGES-1];
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock qualifier and staged downstream reset release (refclk, rst, pll_locked, soft_relock -> pll_rst, sdram_rst, sys_rst, relock_count, timeout_err, state_o)
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 8
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                soft_relock,
  output logic                pll_rst,
  output logic                sdram_rst,
  output logic                sys_rst,
  output logic [RELOCK_W-1:0] relock_count,
  output logic                timeout_err,
  output logic [2:0]          state_o
);
  localparam int CW = $clog2(max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                  max2(LOCK_STABLE_CYCLES, STAGGER_CYCLES))) + 1;
  localparam logic [CW-1:0] RST_END = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_END  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_END = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STG_END = CW'(STAGGER_CYCLES - 1);
  state_t        state, ns;
  logic [CW-1:0] cnt;
  logic          lk, loss, to_err;
  pll_lock_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(refclk),
    .rst(rst),
    .d  (pll_locked),
    .q  (lk)
  );
  // lock loss outranks soft_relock so a simultaneous request still counts as a relock event
  always_comb begin
    ns     = state;
    loss   = 1'b0;
    to_err = 1'b0;
    case (state)
      PLL_RESET: ns = cnt == RST_END ? WAIT_LOCK : PLL_RESET;
      WAIT_LOCK: begin
        to_err = !lk && cnt == TO_END;
        ns     = lk ? STABLE : to_err ? PLL_RESET : WAIT_LOCK;
      end
      STABLE:  ns = !lk ? WAIT_LOCK : soft_relock ? PLL_RESET : cnt == STB_END ? RELEASE : STABLE;
      RELEASE: begin
        loss = !lk;
        ns   = loss || soft_relock ? PLL_RESET : cnt == STG_END ? RUN : RELEASE;
      end
      RUN: begin
        loss = !lk;
        ns   = loss || soft_relock ? PLL_RESET : RUN;
      end
      default: ns = PLL_RESET;
    endcase
  end
  // resets are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      state        <= PLL_RESET;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      sdram_rst    <= 1'b1;
      sys_rst      <= 1'b1;
      relock_count <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state     <= ns;
      cnt       <= ns != state ? '0 : cnt + 1'b1;
      pll_rst   <= ns == PLL_RESET;
      sdram_rst <= !(ns == RELEASE || ns == RUN);
      sys_rst   <= ns != RUN;
      if (loss && relock_count != '1) relock_count <= relock_count + 1'b1;
      if (to_err) timeout_err <= 1'b1;
    end
  assign state_o = state;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed and random checks of pll_lock_sequencer against a phase/elapsed-time model
module tb_pll_lock_sequencer;
  localparam int SYNC = 2;
  localparam int PRC  = 4;
  localparam int LTO  = 32;
  localparam int LSC  = 8;
  localparam int STG  = 3;
  logic       refclk, rst, pll_locked, soft_relock;
  logic       pll_rst, sdram_rst, sys_rst, timeout_err;
  logic [7:0] relock_count;
  logic [2:0] state_o;
  int         n_assert = 0, n_fail = 0;
  int         ph, spent, m_cnt;
  logic       m_terr;
  logic       lk_q[$];
  pll_lock_sequencer #(
    .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT_CYCLES(LTO),
    .LOCK_STABLE_CYCLES(LSC), .STAGGER_CYCLES(STG)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .soft_relock(soft_relock),
    .pll_rst(pll_rst), .sdram_rst(sdram_rst), .sys_rst(sys_rst),
    .relock_count(relock_count), .timeout_err(timeout_err), .state_o(state_o)
  );
  initial refclk = 1'b0;
  always #10 refclk = ~refclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] obs_vec();
    return {17'd0, state_o, pll_rst, sdram_rst, sys_rst, relock_count, timeout_err};
  endfunction
  function automatic logic [31:0] exp_vec();
    return {17'd0, 3'(ph), ph == 0, ph < 3, ph != 4, 8'(m_cnt), m_terr};
  endfunction
  task automatic model_reset();
    ph = 0; spent = 0; m_cnt = 0; m_terr = 1'b0;
    lk_q.delete();
    repeat (SYNC) lk_q.push_back(1'b0);
  endtask
  task automatic go(input int p);
    ph = p; spent = 0;
  endtask
  // phases: 0 PLL held, 1 awaiting lock, 2 qualifying, 3 SDRAM out, 4 running
  task automatic model_edge(input logic pin, input logic sr);
    logic lk;
    lk_q.push_front(pin);
    lk = lk_q.pop_back();
    spent++;
    if (ph == 0) begin
      if (spent == PRC) go(1);
    end else if (ph == 1) begin
      if (lk) go(2);
      else if (spent == LTO) begin m_terr = 1'b1; go(0); end
    end else if (!lk) begin
      if (ph > 2) m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
      go(ph == 2 ? 1 : 0);
    end else if (sr) go(0);
    else if (ph == 2 && spent == LSC) go(3);
    else if (ph == 3 && spent == STG) go(4);
  endtask
  task automatic tick(input logic pin, input logic sr);
    pll_locked = pin; soft_relock = sr;
    @(posedge refclk);
    model_edge(pin, sr);
    #1;
    chk("tick", obs_vec(), exp_vec());
    @(negedge refclk);
  endtask
  task automatic run_until(input int target, input logic pin);
    for (int i = 0; i < 300 && ph != target; i++) tick(pin, 1'b0);
    chk("reach_state", 32'(state_o), 32'(target));
  endtask
  initial begin
    int   t_pll, t_sd, t_sys, t_to;
    logic pin;
    rst = 1'b1; pll_locked = 1'b0; soft_relock = 1'b0;
    repeat (3) @(negedge refclk);
    model_reset();
    chk("reset_vals", obs_vec(), exp_vec());
    rst = 1'b0;
    t_pll = -1; t_sd = -1; t_sys = -1;
    for (int t = 1; t <= 30; t++) begin
      tick(t > 10, 1'b0);
      if (t_pll < 0 && !pll_rst) t_pll = t;
      if (t_sd < 0 && !sdram_rst) t_sd = t;
      if (t_sys < 0 && !sys_rst) t_sys = t;
    end
    chk("pll_rst_fall", t_pll, 4);
    chk("sdram_rst_fall", t_sd, 21);
    chk("sys_rst_fall", t_sys, 24);
    chk("nominal_run", 32'(state_o), 32'd4);
    tick(1'b0, 1'b1);
    t_to = -1;
    for (int t = 1; t <= 80; t++) begin
      tick(1'b0, 1'b0);
      if (t_to < 0 && timeout_err) t_to = t;
    end
    chk("timeout_time", t_to, 36);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
    chk("timeout_count", 32'(relock_count), 32'd0);
    for (int i = 0; i < 100 && !(ph == 2 && spent == 5); i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("glitch_state", 32'(state_o), 32'd1);
    chk("glitch_pll_rst", 32'(pll_rst), 32'd0);
    chk("glitch_count", 32'(relock_count), 32'd0);
    run_until(4, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
    chk("loss_sys_rst", 32'(sys_rst), 32'd1);
    chk("loss_sdram_rst", 32'(sdram_rst), 32'd1);
    chk("loss_count", 32'(relock_count), 32'd1);
    run_until(4, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("prio_count", 32'(relock_count), 32'd2);
    run_until(4, 1'b1);
    tick(1'b1, 1'b1);
    chk("soft_state", 32'(state_o), 32'd0);
    chk("soft_count", 32'(relock_count), 32'd2);
    run_until(4, 1'b1);
    repeat (260) begin
      run_until(4, 1'b1);
      repeat (3) tick(1'b0, 1'b0);
    end
    chk("sat_count", 32'(relock_count), 32'd255);
    run_until(3, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst", obs_vec(), exp_vec());
    chk("async_count", 32'(relock_count), 32'd0);
    @(negedge refclk);
    @(negedge refclk);
    rst = 1'b0;
    pin = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) pin = ~pin;
      tick(pin, $urandom_range(0, 39) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
